// File: rtl/ram_io_responder_pkg.sv
// Shared constants and bus-access decode for the CPU memory-port responder.
// The I/O window is the top quarter of the 18-bit decoded space.
package ram_io_responder_pkg;

   localparam int DATA_W = 8;
   localparam int CNT_W  = 32;

   localparam logic [1:0] IO_REGION = 2'b11;
   localparam logic [2:0] OFF_UART  = 3'd0;
   localparam logic [2:0] OFF_CLK   = 3'd4;

   typedef enum logic [3:0] {
      ACC_NONE,
      ACC_RAM_RD,
      ACC_RAM_WR,
      ACC_UART_RD,
      ACC_UART_WR,
      ACC_CLK_RD,
      ACC_SNAP_RD,
      ACC_STOP_WR,
      ACC_IO_ZERO
   } access_e;

   // Offsets 5..7 read back the bytes latched by the last counter read.
   function automatic access_e decode_access(input logic [17:0] addr, input logic wr);
      access_e acc;
      acc = ACC_NONE;
      if (addr[17:16] != IO_REGION) begin
         acc = wr ? ACC_RAM_WR : ACC_RAM_RD;
      end else if (addr[2:0] == OFF_UART) begin
         acc = wr ? ACC_UART_WR : ACC_UART_RD;
      end else if (addr[2:0] == OFF_CLK) begin
         acc = wr ? ACC_STOP_WR : ACC_CLK_RD;
      end else if (addr[2] && (addr[1:0] != 2'b00)) begin
         acc = wr ? ACC_NONE : ACC_SNAP_RD;
      end else begin
         acc = wr ? ACC_NONE : ACC_IO_ZERO;
      end
      return acc;
   endfunction

endpackage

// File: rtl/ram_io_responder_byte_fifo.sv
// Byte-wide synchronous FIFO; head reads 0x00 whenever the FIFO is empty.
// Push while full and pop while empty are both dropped.
module byte_fifo
   import ram_io_responder_pkg::*;
#(
   parameter int DEPTH = 16
) (
   input  logic                     clk_i,
   input  logic                     rst_i,
   input  logic                     push_i,
   input  logic [DATA_W-1:0]        data_i,
   input  logic                     pop_i,
   output logic [DATA_W-1:0]        head_o,
   output logic                     full_o,
   output logic                     empty_o,
   output logic [$clog2(DEPTH):0]   count_o
);

   localparam int PW = $clog2(DEPTH);

   logic [DATA_W-1:0] slots [0:DEPTH-1];
   logic [PW-1:0]     wrPtr_q, rdPtr_q;
   logic [PW:0]       count_q;
   logic              doPush, doPop;

   assign full_o  = (count_q == (PW+1)'(DEPTH));
   assign empty_o = (count_q == '0);
   assign count_o = count_q;
   assign doPush  = push_i && !full_o;
   assign doPop   = pop_i && !empty_o;
   assign head_o  = empty_o ? '0 : slots[rdPtr_q];

   always_ff @(posedge clk_i) begin
      if (doPush) begin
         slots[wrPtr_q] <= data_i;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         wrPtr_q <= '0;
         rdPtr_q <= '0;
         count_q <= '0;
      end else begin
         if (doPush) begin
            wrPtr_q <= wrPtr_q + 1'b1;
         end
         if (doPop) begin
            rdPtr_q <= rdPtr_q + 1'b1;
         end
         count_q <= count_q + {{PW{1'b0}}, doPush} - {{PW{1'b0}}, doPop};
      end
   end

endmodule

// File: rtl/ram_io_responder.sv
// CPU memory-port responder: RAM, UART FIFOs, cycle counter and stop flag.
// Read data is registered so it is valid for the whole cycle after the address.
module ram_io_responder
   import ram_io_responder_pkg::*;
#(
   parameter int ADDR_WIDTH = 17,
   parameter int FIFO_DEPTH = 16
) (
   input  logic        clk_in,
   input  logic        rst_in,
   input  logic [31:0] mem_a_in,
   input  logic [7:0]  mem_wdata_in,
   input  logic        mem_wr_in,
   output logic [7:0]  mem_rdata_out,
   output logic        rdy_out,
   output logic [7:0]  uart_tx_data_out,
   output logic        uart_tx_valid_out,
   input  logic        uart_tx_ready_in,
   input  logic [7:0]  uart_rx_data_in,
   input  logic        uart_rx_valid_in,
   output logic        uart_rx_ready_out,
   output logic        stop_out
);

   localparam int CW = $clog2(FIFO_DEPTH) + 1;
   localparam logic [CW-1:0] RDY_LIMIT = CW'(FIFO_DEPTH - 2);

   logic [DATA_W-1:0]     ram [0:(1<<ADDR_WIDTH)-1];
   logic [ADDR_WIDTH-1:0] ramAddr;
   access_e               access;
   logic [DATA_W-1:0]     ramRd_q, ioRd_q, ioRd_d, snapByte;
   logic                  rdSrcRam_q, rdSrcRam_d;
   logic [CNT_W-1:0]      counter_q, snapshot_q, snapshot_d;
   logic                  stop_q, stop_d, rdy_q, rdy_d;
   logic                  txPush, txPop, rxPush, rxPop;
   logic [DATA_W-1:0]     txPushData, rxHead;
   logic                  txEmpty, rxFull, rxEmpty;
   logic [CW-1:0]         txCount;
   logic                  unusedTxFull, unusedAddrBits;
   logic [CW-1:0]         unusedRxCount;

   assign ramAddr        = mem_a_in[ADDR_WIDTH-1:0];
   assign access         = rdy_q ? decode_access(mem_a_in[17:0], mem_wr_in) : ACC_NONE;
   assign unusedAddrBits = ^mem_a_in[31:18];

   always_comb begin
      unique case (mem_a_in[1:0])
         2'd1:    snapByte = snapshot_q[15:8];
         2'd2:    snapByte = snapshot_q[23:16];
         default: snapByte = snapshot_q[31:24];
      endcase
   end

   // Only one bus access per cycle, so the I/O side effects are a flat decode.
   always_comb begin
      rdSrcRam_d = rdSrcRam_q;
      ioRd_d     = ioRd_q;
      snapshot_d = snapshot_q;
      stop_d     = stop_q;
      txPush     = 1'b0;
      txPushData = mem_wdata_in;
      rxPop      = 1'b0;
      case (access)
         ACC_RAM_RD: rdSrcRam_d = 1'b1;
         ACC_UART_RD: begin
            rdSrcRam_d = 1'b0;
            ioRd_d     = rxHead;
            rxPop      = !rxEmpty;
         end
         ACC_CLK_RD: begin
            rdSrcRam_d = 1'b0;
            ioRd_d     = counter_q[7:0];
            snapshot_d = counter_q;
         end
         ACC_SNAP_RD: begin
            rdSrcRam_d = 1'b0;
            ioRd_d     = snapByte;
         end
         ACC_IO_ZERO: begin
            rdSrcRam_d = 1'b0;
            ioRd_d     = '0;
         end
         ACC_UART_WR: txPush = (mem_wdata_in != 8'h00);
         ACC_STOP_WR: begin
            stop_d     = 1'b1;
            txPush     = 1'b1;
            txPushData = '0;
         end
         default: ;
      endcase
   end

   assign txPop  = uart_tx_valid_out && uart_tx_ready_in;
   assign rxPush = uart_rx_valid_in && !rxFull;
   assign rdy_d  = (txCount <= RDY_LIMIT);

   always_ff @(posedge clk_in) begin
      if (!rst_in && access == ACC_RAM_WR) begin
         ram[ramAddr] <= mem_wdata_in;
      end
      if (access == ACC_RAM_RD) begin
         ramRd_q <= ram[ramAddr];
      end
   end

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         rdSrcRam_q <= 1'b0;
         ioRd_q     <= '0;
         counter_q  <= '0;
         snapshot_q <= '0;
         stop_q     <= 1'b0;
         rdy_q      <= 1'b1;
      end else begin
         rdSrcRam_q <= rdSrcRam_d;
         ioRd_q     <= ioRd_d;
         counter_q  <= counter_q + 32'd1;
         snapshot_q <= snapshot_d;
         stop_q     <= stop_d;
         rdy_q      <= rdy_d;
      end
   end

   assign mem_rdata_out     = rdSrcRam_q ? ramRd_q : ioRd_q;
   assign rdy_out           = rdy_q;
   assign stop_out          = stop_q;
   assign uart_tx_valid_out = !txEmpty;
   assign uart_rx_ready_out = !rxFull;

   byte_fifo #(.DEPTH(FIFO_DEPTH)) txFifo (
      .clk_i   (clk_in),
      .rst_i   (rst_in),
      .push_i  (txPush),
      .data_i  (txPushData),
      .pop_i   (txPop),
      .head_o  (uart_tx_data_out),
      .full_o  (unusedTxFull),
      .empty_o (txEmpty),
      .count_o (txCount)
   );

   byte_fifo #(.DEPTH(FIFO_DEPTH)) rxFifo (
      .clk_i   (clk_in),
      .rst_i   (rst_in),
      .push_i  (rxPush),
      .data_i  (uart_rx_data_in),
      .pop_i   (rxPop),
      .head_o  (rxHead),
      .full_o  (rxFull),
      .empty_o (rxEmpty),
      .count_o (unusedRxCount)
   );

endmodule

// File: tb/tb_ram_io_responder.sv
// Scoreboard bench for ram_io_responder: a queue-based reference model predicts
// read data, TX bytes and status flags; a negedge monitor compares.
module tb_ram_io_responder;

   localparam int DEPTH = 16;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] memA;
   logic [7:0]  memWdata;
   logic        memWr;
   logic [7:0]  memRdata;
   logic        rdy;
   logic [7:0]  txData;
   logic        txValid;
   logic        txReady;
   logic [7:0]  rxData;
   logic        rxValid;
   logic        rxReady;
   logic        stopFlag;

   always #5 clk = ~clk;

   ram_io_responder #(.ADDR_WIDTH(17), .FIFO_DEPTH(DEPTH)) dut (
      .clk_in            (clk),
      .rst_in            (rst),
      .mem_a_in          (memA),
      .mem_wdata_in      (memWdata),
      .mem_wr_in         (memWr),
      .mem_rdata_out     (memRdata),
      .rdy_out           (rdy),
      .uart_tx_data_out  (txData),
      .uart_tx_valid_out (txValid),
      .uart_tx_ready_in  (txReady),
      .uart_rx_data_in   (rxData),
      .uart_rx_valid_in  (rxValid),
      .uart_rx_ready_out (rxReady),
      .stop_out          (stopFlag)
   );

   int checkCount = 0;
   int passCount  = 0;
   int txSeen     = 0;

   logic [7:0]  expRead [$];
   logic [7:0]  expTx [$];
   bit          readValid = 1'b0;
   bit          modelLive = 1'b0;

   logic [7:0]  mRam [int];
   logic [7:0]  mRxQ [$];
   int          mTxCount;
   bit          mRdy, mStop;
   logic [31:0] mCnt, mSnap;
   logic [7:0]  mHold;

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checkCount++;
      if (actual === expected) begin
         passCount++;
      end else begin
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
      end
   endtask

   // Reference model: one bus transaction per edge, evaluated from pre-edge state.
   always @(posedge clk) begin
      bit         txPop, rxPush, txPush, newRdy;
      logic [7:0] txByte, rv;
      int         off;
      readValid = 1'b0;
      if (rst) begin
         modelLive = 1'b1;
         mTxCount  = 0;
         mRxQ.delete();
         expTx.delete();
         expRead.delete();
         mRdy  = 1'b1;
         mStop = 1'b0;
         mCnt  = 32'd0;
         mSnap = 32'd0;
         mHold = 8'h00;
      end else if (modelLive) begin
         txPop  = (mTxCount > 0) && txReady;
         rxPush = (mRxQ.size() < DEPTH) && rxValid;
         newRdy = (DEPTH - mTxCount) >= 2;
         txPush = 1'b0;
         txByte = 8'h00;
         rv     = 8'h00;
         if (mRdy) begin
            if (memA[17:16] != 2'b11) begin
               if (memWr) mRam[int'(memA[16:0])] = memWdata;
               else begin
                  rv = mRam[int'(memA[16:0])];
                  readValid = 1'b1;
               end
            end else begin
               off = int'(memA[2:0]);
               if (memWr) begin
                  if (off == 0 && memWdata != 8'h00) begin
                     txPush = 1'b1;
                     txByte = memWdata;
                  end else if (off == 4) begin
                     mStop  = 1'b1;
                     txPush = 1'b1;
                  end
               end else begin
                  readValid = 1'b1;
                  if (off == 0) begin
                     if (mRxQ.size() > 0) rv = mRxQ.pop_front();
                  end else if (off == 4) begin
                     mSnap = mCnt;
                     rv    = mCnt[7:0];
                  end else if (off >= 5) begin
                     rv = 8'(mSnap >> (8 * (off - 4)));
                  end
               end
            end
            if (readValid) begin
               expRead.push_back(rv);
               mHold = rv;
            end
         end
         if (txPush) expTx.push_back(txByte);
         mTxCount = mTxCount + int'(txPush) - int'(txPop);
         if (rxPush) mRxQ.push_back(rxData);
         mCnt = mCnt + 32'd1;
         mRdy = newRdy;
      end
   end

   // Monitor: compares whatever the DUT presents against the scoreboard queues.
   always @(negedge clk) begin
      logic [7:0] monExp;
      if (modelLive && !rst) begin
         if (readValid) begin
            if (expRead.size() == 0) begin
               checkCount++;
               $display("[TB] FAIL readQueue: got read data 0x%0h, expected no pending read", memRdata);
            end else begin
               monExp = expRead.pop_front();
               checkOutput("readData", {24'd0, memRdata}, {24'd0, monExp});
            end
         end else begin
            checkOutput("readHold", {24'd0, memRdata}, {24'd0, mHold});
         end
         checkOutput("rdy", {31'd0, rdy}, {31'd0, mRdy});
         checkOutput("stop", {31'd0, stopFlag}, {31'd0, mStop});
         checkOutput("txValid", {31'd0, txValid}, {31'd0, mTxCount > 0});
         checkOutput("rxReady", {31'd0, rxReady}, {31'd0, mRxQ.size() < DEPTH});
         if (txValid && txReady) begin
            txSeen++;
            if (expTx.size() == 0) begin
               checkCount++;
               $display("[TB] FAIL txQueue: got TX byte 0x%0h, expected none", txData);
            end else begin
               monExp = expTx.pop_front();
               checkOutput("txData", {24'd0, txData}, {24'd0, monExp});
            end
         end
      end
   end

   task automatic applyStimulus(input logic [31:0] a, input logic wr, input logic [7:0] d);
      memA     = a;
      memWr    = wr;
      memWdata = d;
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      repeat (n) applyStimulus(32'h0003_0001, 1'b0, 8'h00);
   endtask

   task automatic checkResetState(input string tag);
      @(negedge clk);
      checkOutput({tag, "_rdata"}, {24'd0, memRdata}, 32'h00);
      checkOutput({tag, "_txData"}, {24'd0, txData}, 32'h00);
      checkOutput({tag, "_txValid"}, {31'd0, txValid}, 32'd0);
      checkOutput({tag, "_rdy"}, {31'd0, rdy}, 32'd1);
      checkOutput({tag, "_rxReady"}, {31'd0, rxReady}, 32'd1);
      checkOutput({tag, "_stop"}, {31'd0, stopFlag}, 32'd0);
      @(posedge clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int fillBase;
      int budget;
      rst      = 1'b1;
      memA     = 32'h0003_0001;
      memWr    = 1'b0;
      memWdata = 8'h00;
      txReady  = 1'b0;
      rxData   = 8'h00;
      rxValid  = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      checkResetState("reset");

      for (int i = 0; i < 16; i++) applyStimulus(32'h10 + i, 1'b1, 8'($urandom));
      applyStimulus(32'h0001_0010 & 32'h0000_0010, 1'b1, 8'hA5);
      applyStimulus(32'h0000_0010, 1'b0, 8'h00);
      applyStimulus(32'h0002_0010, 1'b0, 8'h00);

      budget = 0;
      while (mCnt != 32'h0000_01FF && budget < 2000) begin
         idle(1);
         budget++;
      end
      if (mCnt != 32'h0000_01FF) begin
         checkCount++;
         $display("[TB] FAIL counterWait: counter 0x%0h, expected 0x1ff", mCnt);
      end
      for (int o = 4; o < 8; o++) applyStimulus(32'h0003_0000 + o, 1'b0, 8'h00);

      txReady = 1'b1;
      applyStimulus(32'h0003_0000, 1'b1, 8'h41);
      applyStimulus(32'h0003_0000, 1'b1, 8'h00);
      applyStimulus(32'h0003_0000, 1'b1, 8'h42);
      idle(4);

      txReady = 1'b0;
      repeat (DEPTH + 6) applyStimulus(32'h0003_0000, 1'b1, 8'h55);
      idle(2);
      fillBase = txSeen;
      txReady = 1'b1;
      idle(DEPTH + 4);
      checkOutput("fillDrainCount", txSeen - fillBase, DEPTH);

      rxData  = 8'h31;
      rxValid = 1'b1;
      applyStimulus(32'h0003_0000, 1'b0, 8'h00);
      rxValid = 1'b0;
      applyStimulus(32'h0003_0000, 1'b0, 8'h00);
      applyStimulus(32'h0003_0000, 1'b0, 8'h00);

      for (int i = 0; i < 400; i++) begin
         int kind;
         kind    = $urandom_range(0, 9);
         txReady = ($urandom_range(0, 3) != 0);
         rxValid = $urandom_range(0, 1);
         rxData  = 8'($urandom);
         case (kind)
            0, 1, 2, 3: applyStimulus(32'h10 + $urandom_range(0, 15) + ($urandom_range(0, 1) ? 32'h2_0000 : 32'h0),
                                      1'($urandom_range(0, 1)), 8'($urandom));
            4, 5:       applyStimulus(32'h0003_0000, 1'b0, 8'h00);
            6:          applyStimulus(32'h0003_0000, 1'b1, ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom));
            7:          applyStimulus(32'h0003_0000 + $urandom_range(4, 7), 1'b0, 8'h00);
            8:          applyStimulus(32'h0003_0000 + $urandom_range(1, 3), 1'($urandom_range(0, 1)), 8'($urandom));
            default:    applyStimulus(32'h0003_0004, 1'b1, 8'($urandom));
         endcase
      end
      rxValid = 1'b0;
      txReady = 1'b1;
      idle(DEPTH + 4);
      checkOutput("txDrained", expTx.size(), 0);

      rst = 1'b1;
      idle(1);
      rst = 1'b0;
      checkResetState("midReset0");

      txReady = 1'b0;
      applyStimulus(32'h0003_0004, 1'b1, 8'h00);
      applyStimulus(32'h0003_0000, 1'b1, 8'h61);
      applyStimulus(32'h0003_0000, 1'b1, 8'h62);
      idle(1);
      txReady = 1'b1;
      idle(1);
      txReady = 1'b0;
      rxData  = 8'h77;
      rxValid = 1'b1;
      idle(1);
      rxValid = 1'b0;
      rst = 1'b1;
      idle(1);
      rst = 1'b0;
      checkResetState("midReset");
      applyStimulus(32'h0000_0010, 1'b0, 8'h00);
      applyStimulus(32'h0002_0015, 1'b0, 8'h00);
      applyStimulus(32'h0003_0000, 1'b0, 8'h00);
      idle(3);

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule

// File: doc/ram_io_responder.md
# ram_io_responder

Bus-side responder for the CPU's byte-wide memory port: 128 KB RAM plus memory-mapped I/O (UART TX/RX, cycle counter, program stop). Sits outside the CPU top; consumes its mem_a/mem_dout/mem_wr, drives its mem_din and rdy_in. Provides the 1-cycle read latency the CPU's memory controller relies on. Buffers UART traffic in FIFOs and back-pressures the CPU through the ready line.

## Interface
Parameters:
- ADDR_WIDTH, 17, RAM byte address width (2^ADDR_WIDTH bytes)
- FIFO_DEPTH, 16, entries per UART FIFO (power of two, ≥4)

Ports:
- clk_in  in  1  system clock; the only clock
- rst_in  in  1  reset, synchronous, active-high
- mem_a_in  in  32  byte address from CPU; only [17:0] decoded
- mem_wdata_in  in  8  write data from CPU
- mem_wr_in  in  1  1 = write, 0 = read
- mem_rdata_out  out  8  read data to CPU
- rdy_out  out  1  to CPU rdy_in; low pauses CPU
- uart_tx_data_out  out  8  TX FIFO head byte
- uart_tx_valid_out  out  1  TX FIFO non-empty
- uart_tx_ready_in  in  1  UART accepts head byte
- uart_rx_data_in  in  8  received byte
- uart_rx_valid_in  in  1  received byte valid
- uart_rx_ready_out  out  1  RX FIFO not full
- stop_out  out  1  sticky program-stop flag

## Operation
- Transactions accepted only in cycles with rdy_out=1; with rdy_out=0 the bus is ignored (no RAM write, no FIFO push/pop, no snapshot, mem_rdata_out holds).
- Decode: mem_a_in[17:16]==2'b11 → I/O; otherwise RAM at mem_a_in[ADDR_WIDTH-1:0] (0x20000–0x2FFFF alias into RAM).
- RAM read: mem_rdata_out ← ram[addr] at clock edge. RAM write: ram[addr] ← mem_wdata_in at clock edge. RAM array has no reset.
- I/O offset mem_a_in[2:0]:
  - 0 read: RX FIFO non-empty → pop, return head; empty → return 0x00, no pop.
  - 0 write: data ≠ 0x00 → push to TX FIFO; 0x00 ignored.
  - 4 read: latch 32-bit cycle counter into snapshot, return counter[7:0] (current value, same edge as latch).
  - 5/6/7 read: return snapshot byte 1/2/3 (little-endian); snapshot unchanged.
  - 4 write: stop_out ← 1 (sticky until reset); push 0x00 to TX FIFO.
  - Other offsets/addresses in I/O region: read 0x00, write ignored.
- Cycle counter: 32-bit, +1 every clock (independent of rdy_out), wraps 0xFFFFFFFF → 0.
- rdy_out registered: next value = (TX free entries ≥ 2). Guarantees a write accepted in the cycle rdy_out falls still fits.
- TX: pop when uart_tx_valid_out && uart_tx_ready_in. RX: push when uart_rx_valid_in && uart_rx_ready_out.
- Simultaneous push+pop on either FIFO: count unchanged; on empty FIFO, pop does not occur (RX read returns 0x00); full TX never receives push (rdy gating).

## Timing
- Read latency 1: address presented in cycle N, data on mem_rdata_out throughout cycle N+1 (CPU samples at end of N+1).
- Writes commit at the edge ending the presenting cycle; a read of the same address in N+1 returns new data.
- UART handshakes: data/valid stable until accepted; transfer occurs on the edge where valid&&ready.
- Reset values: mem_rdata_out=0x00, rdy_out=1, uart_tx_valid_out=0, uart_tx_data_out=0x00, uart_rx_ready_out=1, stop_out=0, counter=0, snapshot=0, both FIFOs empty.
- Reset mid-operation: FIFO contents discarded, pending read data lost; RAM contents kept.

## Structure
- Shared package: I/O region select (2'b11), offsets (UART=0, CLK/STOP=4), data/byte width constants.
- Sub-module byte_fifo (parameter DEPTH; push/pop/full/empty/count/head), instantiated twice (TX, RX).
- Top holds RAM array, decode, counter, snapshot, stop flag, rdy_out register.

## Test plan
- Write 0xA5 to 0x00010, read 0x00010 → mem_rdata_out=0xA5 in following cycle; read 0x20010 → 0xA5 (alias).
- Write 0x41,0x00,0x42 to 0x30000 with uart_tx_ready_in=1 → TX stream 0x41,0x42 only.
- Hold uart_tx_ready_in=0, write 0x55 repeatedly → rdy_out falls when 2 entries free, FIFO ends at exactly DEPTH entries, no byte lost; release ready → all DEPTH bytes emitted, rdy_out returns.
- Counter at 0x000001FF: read 0x30004..0x30007 on consecutive cycles → bytes 0xFF,0x01,0x00,0x00 despite counter advancing.
- RX push 0x31 while reading 0x30000 in same cycle on empty FIFO → returns 0x00; next read → 0x31; further read → 0x00.
- Write 0x30004 → stop_out=1, TX emits 0x00; assert rst_in mid-stream → stop_out=0, FIFOs empty, rdy_out=1, RAM data retained.
